// File: rtl/apb_pwm.sv
// apb_pwm: APB-programmable PWM generator with period-aligned shadow updates
module apb_pwm #(
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PWM_OUT,
    output logic        PWM_IRQ
);
    logic [2:0]           ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] period_q, period_d, duty_q, duty_d;
    logic [CNT_WIDTH-1:0] per_sh_q, per_sh_d, duty_sh_q, duty_sh_d, cnt_q, cnt_d;
    logic [PRE_WIDTH-1:0] presc_q, presc_d, pre_q, pre_d;
    logic                 wrap_q, wrap_d, pwm_q, pwm_d;
    logic [2:0]           idx;
    logic                 wr, en, tick, wrap_evt, unused_bits;

    assign idx         = PADDR[4:2];
    assign wr          = PSEL & PENABLE & PWRITE;
    assign en          = ctrl_q[0];
    assign tick        = en & (pre_q == presc_q);
    assign wrap_evt    = tick & (cnt_q == per_sh_q);
    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign PWM_OUT     = pwm_q;
    assign PWM_IRQ     = wrap_q & ctrl_q[2];
    assign unused_bits = ^{PADDR[11:5], PADDR[1:0], PWDATA};

    // Register file writes; a W1C on the wrap edge loses to the new wrap
    always_comb begin
        ctrl_d   = (wr && idx == 3'd0) ? PWDATA[2:0] : ctrl_q;
        period_d = (wr && idx == 3'd1) ? PWDATA[CNT_WIDTH-1:0] : period_q;
        duty_d   = (wr && idx == 3'd2) ? PWDATA[CNT_WIDTH-1:0] : duty_q;
        presc_d  = (wr && idx == 3'd5) ? PWDATA[PRE_WIDTH-1:0] : presc_q;
        wrap_d   = wrap_evt ? 1'b1 : (wr && idx == 3'd3 && PWDATA[0]) ? 1'b0 : wrap_q;
    end

    // Shadows track live registers while idle and reload only at wrap when running
    always_comb begin
        per_sh_d  = (!en || wrap_evt) ? period_q : per_sh_q;
        duty_sh_d = (!en || wrap_evt) ? duty_q : duty_sh_q;
        pre_d     = (!en || tick) ? '0 : pre_q + 1'b1;
        cnt_d     = (!en || wrap_evt) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
        pwm_d     = (en & (cnt_q < duty_sh_q)) ^ ctrl_q[1];
    end

    // Combinational read mux, zero outside read accesses
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (idx)
                3'd0:    PRDATA[2:0] = ctrl_q;
                3'd1:    PRDATA[CNT_WIDTH-1:0] = period_q;
                3'd2:    PRDATA[CNT_WIDTH-1:0] = duty_q;
                3'd3:    PRDATA[0] = wrap_q;
                3'd4:    PRDATA[CNT_WIDTH-1:0] = cnt_q;
                3'd5:    PRDATA[PRE_WIDTH-1:0] = presc_q;
                default: PRDATA = '0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q    <= '0;
            period_q  <= '1;
            duty_q    <= '0;
            presc_q   <= '0;
            wrap_q    <= 1'b0;
            per_sh_q  <= '1;
            duty_sh_q <= '0;
            pre_q     <= '0;
            cnt_q     <= '0;
            pwm_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            presc_q   <= presc_d;
            wrap_q    <= wrap_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
        end
    end
endmodule

// File: tb/tb_apb_pwm.sv
// tb_apb_pwm: directed and randomized checks of apb_pwm against a phase-based model
module tb_apb_pwm;
    logic        PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, PWM_OUT, PWM_IRQ;
    int          checks = 0, passed = 0;

    apb_pwm dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PWM_OUT(PWM_OUT), .PWM_IRQ(PWM_IRQ)
    );

    always #5 PCLK = ~PCLK;

    // Model: m_t is the PCLK cycle index inside the current period
    logic        m_en, m_pol, m_irqen, m_wrap, m_pwm;
    logic [15:0] m_period, m_duty, m_per_sh, m_duty_sh;
    logic [7:0]  m_presc;
    int          m_t;

    task automatic model_reset();
        m_en = 0; m_pol = 0; m_irqen = 0; m_wrap = 0; m_pwm = 0;
        m_period = 16'hFFFF; m_duty = 0; m_per_sh = 16'hFFFF; m_duty_sh = 0;
        m_presc = 0; m_t = 0;
    endtask

    task automatic model_edge(input logic w, input logic [2:0] a, input logic [31:0] d);
        int len;
        logic set;
        set = 0;
        if (!m_en) begin
            m_per_sh = m_period; m_duty_sh = m_duty; m_t = 0; m_pwm = m_pol;
        end else begin
            len = (int'(m_per_sh) + 1) * (int'(m_presc) + 1);
            m_pwm = m_pol ^ ((m_t / (int'(m_presc) + 1)) < int'(m_duty_sh));
            if (m_t == len - 1) begin
                set = 1; m_t = 0; m_per_sh = m_period; m_duty_sh = m_duty;
            end else m_t++;
        end
        if (set) m_wrap = 1;
        else if (w && a == 3 && d[0]) m_wrap = 0;
        if (w) begin
            if (a == 0) begin m_en = d[0]; m_pol = d[1]; m_irqen = d[2]; end
            if (a == 1) m_period = d[15:0];
            if (a == 2) m_duty = d[15:0];
            if (a == 5) m_presc = d[7:0];
        end
    endtask

    function automatic logic [31:0] mread(input logic [2:0] i);
        case (i)
            3'd0: return {29'b0, m_irqen, m_pol, m_en};
            3'd1: return 32'(m_period);
            3'd2: return 32'(m_duty);
            3'd3: return 32'(m_wrap);
            3'd4: return 32'(m_t / (int'(m_presc) + 1));
            3'd5: return 32'(m_presc);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        logic w;
        logic [2:0] a;
        logic [31:0] d;
        w = PSEL & PENABLE & PWRITE; a = PADDR[4:2]; d = PWDATA;
        @(posedge PCLK);
        model_edge(w, a, d);
        #1;
        chk("pwm_out", 32'(PWM_OUT), 32'(m_pwm));
        chk("pwm_irq", 32'(PWM_IRQ), 32'(m_wrap & m_irqen));
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
        cyc();
        PENABLE = 1;
        cyc();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, input string tag);
        PSEL = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
        #1 chk(tag, PRDATA, mread(a[4:2]));
        cyc();
        PENABLE = 1;
        cyc();
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic wait_t(input int k);
        int n = 0;
        while (!(m_en && m_t == k) && n < 300) begin cyc(); n++; end
        chk("wait_phase", 32'(m_en && m_t == k), 32'd1);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin cyc(); h += int'(PWM_OUT); end
    endtask

    initial begin
        int h;
        logic [31:0] r;
        model_reset();
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1;
        apb_write(12'h004, 32'd6);
        apb_write(12'h008, 32'd2);
        apb_write(12'h000, 32'd5);
        repeat (15) cyc();
        #3 PRESETn = 0;
        #1;
        chk("rst_pwm", 32'(PWM_OUT), 32'd0);
        chk("rst_irq", 32'(PWM_IRQ), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd1);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        model_reset();
        @(negedge PCLK) PRESETn = 1;
        #1;
        chk("idle_prdata", PRDATA, 32'd0);
        apb_read(12'h004, "rst_period");
        chk("rst_period_const", mread(3'd1), 32'h0000FFFF);
        apb_read(12'h008, "rst_duty");
        apb_read(12'h000, "rst_ctrl");
        apb_read(12'h010, "rst_count");
        apb_read(12'h018, "rd_18");
        apb_read(12'h01C, "rd_1c");
        apb_write(12'h018, 32'hFFFFFFFF);
        apb_read(12'h018, "rd_18_after_wr");

        apb_write(12'h014, 32'd0);
        apb_write(12'h004, 32'd9);
        apb_write(12'h008, 32'd3);
        apb_write(12'h000, 32'd1);
        count_high(20, h);
        chk("duty3_high", 32'(h), 32'd6);
        apb_read(12'h010, "count_run");
        apb_read(12'h00C, "status_run");

        wait_t(5);
        apb_write(12'h008, 32'd7);
        apb_read(12'h008, "duty_live");
        wait_t(0);
        count_high(10, h);
        chk("duty7_high", 32'(h), 32'd7);

        apb_write(12'h000, 32'd0);
        apb_write(12'h00C, 32'd1);
        apb_write(12'h014, 32'd3);
        apb_write(12'h004, 32'd4);
        apb_write(12'h008, 32'd2);
        apb_write(12'h000, 32'd7);
        count_high(20, h);
        chk("pol_low", 32'(20 - h), 32'd8);
        wait_t(5);
        chk("irq_set", 32'(PWM_IRQ), 32'd1);
        apb_write(12'h00C, 32'd1);
        chk("irq_w1c", 32'(PWM_IRQ), 32'd0);
        wait_t(18);
        apb_write(12'h00C, 32'd1);
        chk("irq_set_wins", 32'(PWM_IRQ), 32'd1);
        apb_read(12'h00C, "status_set_wins");

        apb_write(12'h000, 32'd0);
        apb_write(12'h014, 32'd0);
        apb_write(12'h004, 32'd4);
        apb_write(12'h008, 32'd0);
        apb_write(12'h000, 32'd1);
        count_high(10, h);
        chk("duty0_const", 32'(h), 32'd0);
        apb_write(12'h008, 32'd5);
        repeat (8) cyc();
        count_high(10, h);
        chk("duty5_const", 32'(h), 32'd10);
        apb_write(12'h004, 32'd0);
        apb_write(12'h008, 32'd1);
        repeat (8) cyc();
        count_high(10, h);
        chk("per0_const", 32'(h), 32'd10);
        apb_write(12'h00C, 32'd1);
        apb_read(12'h00C, "per0_wrap");
        chk("per0_wrap_const", mread(3'd3), 32'd1);

        apb_write(12'h000, 32'd0);
        apb_write(12'h004, 32'd9);
        apb_write(12'h008, 32'd4);
        apb_write(12'h000, 32'd3);
        wait_t(5);
        apb_write(12'h000, 32'd2);
        cyc();
        chk("dis_pwm_pol", 32'(PWM_OUT), 32'd1);
        apb_read(12'h010, "dis_count");
        apb_write(12'h004, 32'd5);
        apb_write(12'h008, 32'd2);
        apb_write(12'h000, 32'd3);
        repeat (14) cyc();

        for (int i = 0; i < 250; i++) begin
            r = $urandom();
            case ($urandom_range(0, 6))
                0: apb_write(12'h004, {r[31:16], 16'($urandom_range(0, 12))});
                1: apb_write(12'h008, {r[31:16], 16'($urandom_range(0, 14))});
                2: apb_write(12'h000, {r[31:3], 3'($urandom_range(0, 7))});
                3: apb_write(12'h00C, r);
                4: if (!m_en) apb_write(12'h014, {r[31:8], 8'($urandom_range(0, 3))});
                   else cyc();
                5: apb_read({7'd0, r[4:0]}, "rand_read");
                default: repeat ($urandom_range(1, 6)) cyc();
            endcase
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
